// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared types and constants for the ysyx_23060332 instruction fetch unit.
package ysyx_23060332_ifu_pkg;

  localparam int          INST_W       = 32;  // InstBus
  localparam int          ADDR_W       = 32;  // InstAddrBus
  localparam logic [31:0] RESET_PC_VAL = 32'h8000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ysyx_23060332_ifu_if.sv
// Instruction-memory and IDU-facing handshake bundle of the IFU.
interface ysyx_23060332_ifu_if;
  import ysyx_23060332_ifu_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              imem_resp_err;

  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output inst_valid, inst_o, inst_addr, inst_err,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  inst_valid, inst_o, inst_addr, inst_err,
    output inst_ready
  );
endinterface

// File: rtl/ysyx_23060332_pc_reg.sv
// Program counter: redirect load has priority over the +4 increment.
module ysyx_23060332_pc_reg
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_VAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc,
  output logic [31:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    if (load)     pc_nxt = word_align(load_addr);
    else if (inc) pc_nxt = pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_nxt;
  end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: one outstanding word fetch, redirect with
// wrong-path kill, and a one-entry output buffer towards the IDU.
//
// state | meaning
// IDLE  | after reset, move to REQ next edge
// REQ   | request pc to imem, held until accepted
// WAIT  | waiting for the response (dropped if kill or redirect)
// OUT   | buffered instruction offered to IDU
module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_VAL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                jump_flag,
  input  logic [31:0]         jump_addr,
  ysyx_23060332_ifu_if.master bus
);

  ifu_state_e  state, state_nxt;
  logic        kill, kill_nxt;
  logic        pc_inc, capture;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr;
  logic [31:0] buf_inst, buf_addr;
  logic        buf_err;

  ysyx_23060332_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (jump_flag),
    .load_addr (jump_addr),
    .inc       (pc_inc),
    .pc        (pc),
    .pc_nxt    (pc_nxt)
  );

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    pc_inc    = 1'b0;
    capture   = 1'b0;
    case (state)
      IFU_IDLE: state_nxt = IFU_REQ;
      IFU_REQ: begin
        if (bus.imem_req_ready) state_nxt = IFU_WAIT;
        if (jump_flag)          kill_nxt  = 1'b1;
      end
      IFU_WAIT: begin
        if (bus.imem_resp_valid) begin
          kill_nxt = 1'b0;
          if (kill || jump_flag) begin
            state_nxt = IFU_REQ;
          end else begin
            capture   = 1'b1;
            state_nxt = IFU_OUT;
          end
        end else if (jump_flag) begin
          kill_nxt = 1'b1;
        end
      end
      IFU_OUT: begin
        if (jump_flag) begin
          state_nxt = IFU_REQ;
        end else if (bus.inst_ready) begin
          pc_inc    = 1'b1;
          state_nxt = IFU_REQ;
        end
      end
      default: state_nxt = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IFU_IDLE;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
    end
  end

  // Request address is latched on REQ entry so a redirect during REQ
  // cannot disturb a request that is still waiting for ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     req_addr <= RESET_PC;
    else if (state_nxt == IFU_REQ && state != IFU_REQ) req_addr <= pc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_inst <= 32'h0;
      buf_addr <= RESET_PC;
      buf_err  <= 1'b0;
    end else if (capture) begin
      buf_inst <= bus.imem_resp_data;
      buf_addr <= pc;
      buf_err  <= bus.imem_resp_err;
    end
  end

  assign bus.imem_req_valid = (state == IFU_REQ);
  assign bus.imem_req_addr  = req_addr;
  assign bus.inst_valid     = (state == IFU_OUT);
  assign bus.inst_o         = buf_inst;
  assign bus.inst_addr      = buf_addr;
  assign bus.inst_err       = buf_err;

endmodule
